// File: rtl/lsu_mmio_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mmio_ctrl
// Description : Load/store unit for the multicycle core. Accepts one request
//               at a time and routes it either to data memory (variable
//               latency, mem_ready handshake) or to N_IO on-chip I/O channels
//               mapped in a 16-word window starting at IO_BASE.
//               Optional feature macro: LSU_TIMEOUT_EN (memory wait timeout).
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_mmio_ctrl #(
    parameter int          DW      = 16,
    parameter int          AW      = 16,
    parameter int          N_IO    = 2,
    parameter int unsigned IO_BASE = 'hFF00,
    parameter int          TIMEOUT = 255
) (
    input  logic                 clock_i,
    input  logic                 rst_i,
    // core request
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_write_i,
    input  logic [AW-1:0]        req_addr_i,
    input  logic [DW-1:0]        req_wdata_i,
    // core response
    output logic                 resp_valid_o,
    output logic [DW-1:0]        resp_rdata_o,
    output logic                 resp_err_o,
    // data memory
    output logic [AW-1:0]        mem_addr_o,
    output logic [DW-1:0]        mem_wdata_o,
    output logic                 mem_re_o,
    output logic                 mem_we_o,
    input  logic                 mem_ready_i,
    input  logic [DW-1:0]        mem_rdata_i,
    // I/O channels
    input  logic [N_IO*DW-1:0]   io_in_i,
    output logic [N_IO*DW-1:0]   io_out_o,
    output logic [N_IO-1:0]      io_out_strobe_o
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter sanity checks
    // ------------------------------------------------------------------------
    if ((N_IO < 1) || (N_IO > 16)) begin : g_bad_n_io
        $error("lsu_mmio_ctrl: N_IO must be in 1..16");
    end

    if ((longint'(IO_BASE) + 64'sd15) > ((longint'(1) << AW) - 64'sd1)) begin : g_bad_io_base
        $error("lsu_mmio_ctrl: I/O window exceeds the address space");
    end

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("lsu_mmio_ctrl: TIMEOUT must be at least 1");
    end

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [AW-1:0] c_io_base = AW'(IO_BASE);
    localparam logic [AW-1:0] c_io_last = AW'(IO_BASE + 15);

`ifdef LSU_TIMEOUT_EN
    localparam int            c_cw      = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_cw-1:0] c_tmo   = c_cw'(TIMEOUT);
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MEM  = 2'd1,
        S_RESP = 2'd2
    } state_e;

    // ------------------------------------------------------------------------
    // Registers (every output is driven straight from one of these)
    // ------------------------------------------------------------------------
    state_e                       state_q;
    logic                         req_ready_q;
    logic                         resp_valid_q;
    logic [DW-1:0]                resp_rdata_q;
    logic                         resp_err_q;
    logic [AW-1:0]                mem_addr_q;
    logic [DW-1:0]                mem_wdata_q;
    logic                         mem_re_q;
    logic                         mem_we_q;
    logic [N_IO-1:0][DW-1:0]      io_out_q;
    logic [N_IO-1:0]              io_strobe_q;
`ifdef LSU_TIMEOUT_EN
    logic [c_cw-1:0]              wait_cnt_q;
`endif

    // ------------------------------------------------------------------------
    // Address decode of the incoming request
    // ------------------------------------------------------------------------
    logic                         w_in_win;
    logic [3:0]                   w_chan;
    logic                         w_io_hit;
    logic [N_IO-1:0]              w_chan_sel;
    logic [DW-1:0]                w_io_rdata;

    // Unsigned range check first, so addresses below IO_BASE never alias
    // into the window through subtraction wrap-around.
    assign w_in_win = (req_addr_i >= c_io_base) && (req_addr_i <= c_io_last);
    assign w_chan   = 4'(req_addr_i - c_io_base);
    assign w_io_hit = w_in_win && ({1'b0, w_chan} < 5'(N_IO));

    // One-hot channel select and read mux over the input channels
    always_comb begin
        w_chan_sel = '0;
        w_io_rdata = '0;
        for (int i = 0; i < N_IO; i++) begin
            if (w_chan == 4'(i)) begin
                w_chan_sel[i] = 1'b1;
                w_io_rdata    = io_in_i[i*DW +: DW];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clock_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_re_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            io_out_q     <= '0;
            io_strobe_q  <= '0;
`ifdef LSU_TIMEOUT_EN
            wait_cnt_q   <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        if (w_io_hit) begin
                            // I/O channel: completes without touching memory
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b0;
                            if (req_write_i) begin
                                resp_rdata_q <= '0;
                                io_strobe_q  <= w_chan_sel;
                                for (int i = 0; i < N_IO; i++) begin
                                    if (w_chan_sel[i]) begin
                                        io_out_q[i] <= req_wdata_i;
                                    end
                                end
                            end else begin
                                resp_rdata_q <= w_io_rdata;
                            end
                        end else if (w_in_win) begin
                            // Unpopulated channel in the I/O window
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                        end else begin
                            // Data memory access, strobes held until mem_ready
                            state_q     <= S_MEM;
                            mem_addr_q  <= req_addr_i;
                            mem_wdata_q <= req_wdata_i;
                            mem_re_q    <= ~req_write_i;
                            mem_we_q    <= req_write_i;
`ifdef LSU_TIMEOUT_EN
                            wait_cnt_q  <= '0;
`endif
                        end
                    end
                end

                S_MEM: begin
                    if (mem_ready_i) begin
                        // A ready on the timeout cycle still completes normally
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= mem_re_q ? mem_rdata_i : '0;
                        mem_addr_q   <= '0;
                        mem_wdata_q  <= '0;
                        mem_re_q     <= 1'b0;
                        mem_we_q     <= 1'b0;
`ifdef LSU_TIMEOUT_EN
                    end else if (wait_cnt_q == c_tmo) begin
                        // Memory never answered: abandon the access
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        resp_rdata_q <= '0;
                        mem_addr_q   <= '0;
                        mem_wdata_q  <= '0;
                        mem_re_q     <= 1'b0;
                        mem_we_q     <= 1'b0;
                    end else begin
                        wait_cnt_q   <= wait_cnt_q + 1'b1;
`endif
                    end
                end

                S_RESP: begin
                    // Single-cycle response, then reopen for the next request
                    state_q      <= S_IDLE;
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= '0;
                    io_strobe_q  <= '0;
                end

                default: begin
                    state_q      <= S_IDLE;
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= '0;
                    mem_re_q     <= 1'b0;
                    mem_we_q     <= 1'b0;
                    io_strobe_q  <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output wiring
    // ------------------------------------------------------------------------
    assign req_ready_o     = req_ready_q;
    assign resp_valid_o    = resp_valid_q;
    assign resp_rdata_o    = resp_rdata_q;
    assign resp_err_o      = resp_err_q;
    assign mem_addr_o      = mem_addr_q;
    assign mem_wdata_o     = mem_wdata_q;
    assign mem_re_o        = mem_re_q;
    assign mem_we_o        = mem_we_q;
    assign io_out_o        = io_out_q;
    assign io_out_strobe_o = io_strobe_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mmio_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_mmio_ctrl
// Description : Directed self-checking bench for lsu_mmio_ctrl (DW=16, AW=16,
//               N_IO=2, IO_BASE='hFF00, TIMEOUT=4). Timeout steps run when
//               LSU_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_mmio_ctrl;

    localparam int DW   = 16;
    localparam int AW   = 16;
    localparam int N_IO = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic                req_valid;
    logic                req_ready;
    logic                req_write;
    logic [AW-1:0]       req_addr;
    logic [DW-1:0]       req_wdata;
    logic                resp_valid;
    logic [DW-1:0]       resp_rdata;
    logic                resp_err;
    logic [AW-1:0]       mem_addr;
    logic [DW-1:0]       mem_wdata;
    logic                mem_re;
    logic                mem_we;
    logic                mem_ready;
    logic [DW-1:0]       mem_rdata;
    logic [N_IO*DW-1:0]  io_in;
    logic [N_IO*DW-1:0]  io_out;
    logic [N_IO-1:0]     io_strobe;

    int n_vec = 0;
    int n_bad = 0;

    lsu_mmio_ctrl #(
        .DW      (DW),
        .AW      (AW),
        .N_IO    (N_IO),
        .IO_BASE ('hFF00),
        .TIMEOUT (4)
    ) dut (
        .clock_i         (clk),
        .rst_i           (rst),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_write_i     (req_write),
        .req_addr_i      (req_addr),
        .req_wdata_i     (req_wdata),
        .resp_valid_o    (resp_valid),
        .resp_rdata_o    (resp_rdata),
        .resp_err_o      (resp_err),
        .mem_addr_o      (mem_addr),
        .mem_wdata_o     (mem_wdata),
        .mem_re_o        (mem_re),
        .mem_we_o        (mem_we),
        .mem_ready_i     (mem_ready),
        .mem_rdata_i     (mem_rdata),
        .io_in_i         (io_in),
        .io_out_o        (io_out),
        .io_out_strobe_o (io_strobe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    // Present one request at a negedge; returns at the next negedge (accept+1)
    task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        @(negedge clk);
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    // Hard stop if the sequence below ever stalls
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected sequence end");
        $fatal(1, "simulation stalled");
    end

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        io_in     = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req_ready",  32'(req_ready),  32'h1);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_mem_re",     32'(mem_re),     32'h0);
        chk("rst_mem_we",     32'(mem_we),     32'h0);
        chk("rst_io_out",     io_out,          32'h0);
        chk("rst_strobe",     32'(io_strobe),  32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_req_ready", 32'(req_ready), 32'h1);

        // I/O store to channel 1
        issue(1'b1, 16'hFF01, 16'h1234);
        chk("ios_valid",  32'(resp_valid), 32'h1);
        chk("ios_err",    32'(resp_err),   32'h0);
        chk("ios_rdata",  32'(resp_rdata), 32'h0);
        chk("ios_io_out", io_out,          32'h1234_0000);
        chk("ios_strobe", 32'(io_strobe),  32'h2);
        chk("ios_ready",  32'(req_ready),  32'h0);
        chk("ios_mem_we", 32'(mem_we),     32'h0);
        @(negedge clk);
        chk("ios_valid_end",  32'(resp_valid), 32'h0);
        chk("ios_strobe_end", 32'(io_strobe),  32'h0);
        chk("ios_ready_end",  32'(req_ready),  32'h1);
        chk("ios_io_hold",    io_out,          32'h1234_0000);

        // I/O loads from channel 0 and channel 1
        io_in = 32'hCAFE_BEEF;
        issue(1'b0, 16'hFF00, 16'h0);
        chk("iol0_valid",  32'(resp_valid), 32'h1);
        chk("iol0_rdata",  32'(resp_rdata), 32'hBEEF);
        chk("iol0_err",    32'(resp_err),   32'h0);
        chk("iol0_mem_re", 32'(mem_re),     32'h0);
        @(negedge clk);
        issue(1'b0, 16'hFF01, 16'h0);
        io_in = 32'h0;
        chk("iol1_rdata", 32'(resp_rdata), 32'hCAFE);
        @(negedge clk);
        chk("iol1_rdata_clr", 32'(resp_rdata), 32'h0);

        // Memory load with three wait cycles
        issue(1'b0, 16'h0040, 16'h0);
        for (int i = 1; i <= 4; i++) begin
            chk("mload_re",    32'(mem_re),     32'h1);
            chk("mload_we",    32'(mem_we),     32'h0);
            chk("mload_addr",  32'(mem_addr),   32'h0040);
            chk("mload_valid", 32'(resp_valid), 32'h0);
            if (i == 4) begin
                mem_ready = 1'b1;
                mem_rdata = 16'h5A5A;
            end
            @(negedge clk);
        end
        mem_ready = 1'b0;
        mem_rdata = 16'h0;
        chk("mload_resp",  32'(resp_valid), 32'h1);
        chk("mload_rdata", 32'(resp_rdata), 32'h5A5A);
        chk("mload_err",   32'(resp_err),   32'h0);
        chk("mload_re_off", 32'(mem_re),    32'h0);
        @(negedge clk);
        chk("mload_resp_end", 32'(resp_valid), 32'h0);
        chk("mload_ready",    32'(req_ready),  32'h1);

        // mem_ready while idle is ignored
        mem_ready = 1'b1;
        mem_rdata = 16'hDEAD;
        repeat (2) @(negedge clk);
        chk("idle_ready_ignored", 32'(resp_valid), 32'h0);
        mem_ready = 1'b0;
        mem_rdata = 16'h0;

        // Memory store with zero wait
        issue(1'b1, 16'h0100, 16'hABCD);
        chk("mstore_we",    32'(mem_we),    32'h1);
        chk("mstore_re",    32'(mem_re),    32'h0);
        chk("mstore_wdata", 32'(mem_wdata), 32'hABCD);
        chk("mstore_addr",  32'(mem_addr),  32'h0100);
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        chk("mstore_valid",  32'(resp_valid), 32'h1);
        chk("mstore_rdata",  32'(resp_rdata), 32'h0);
        chk("mstore_we_off", 32'(mem_we),     32'h0);
        @(negedge clk);

        // Unpopulated I/O channels
        issue(1'b1, 16'hFF05, 16'h9999);
        chk("werr_valid",  32'(resp_valid), 32'h1);
        chk("werr_err",    32'(resp_err),   32'h1);
        chk("werr_rdata",  32'(resp_rdata), 32'h0);
        chk("werr_strobe", 32'(io_strobe),  32'h0);
        chk("werr_io_out", io_out,          32'h1234_0000);
        @(negedge clk);
        io_in = 32'hFFFF_FFFF;
        issue(1'b0, 16'hFF0F, 16'h0);
        chk("werr_top_err",   32'(resp_err),   32'h1);
        chk("werr_top_rdata", 32'(resp_rdata), 32'h0);
        io_in = 32'h0;
        @(negedge clk);

        // Address just below the window goes to memory
        issue(1'b0, 16'hFEFF, 16'h0);
        chk("below_re",    32'(mem_re),     32'h1);
        chk("below_addr",  32'(mem_addr),   32'hFEFF);
        chk("below_valid", 32'(resp_valid), 32'h0);
        mem_ready = 1'b1;
        mem_rdata = 16'h0777;
        @(negedge clk);
        mem_ready = 1'b0;
        mem_rdata = 16'h0;
        chk("below_resp",  32'(resp_valid), 32'h1);
        chk("below_err",   32'(resp_err),   32'h0);
        chk("below_rdata", 32'(resp_rdata), 32'h0777);
        @(negedge clk);

        // Asynchronous reset during a memory access
        issue(1'b0, 16'h0200, 16'h0);
        chk("arst_pre_re", 32'(mem_re), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("arst_re_drop", 32'(mem_re),    32'h0);
        chk("arst_ready",   32'(req_ready), 32'h1);
        chk("arst_io_out",  io_out,         32'h0);
        @(negedge clk);
        chk("arst_no_resp", 32'(resp_valid), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("arst_rel_resp",  32'(resp_valid), 32'h0);
        chk("arst_rel_ready", 32'(req_ready),  32'h1);
        chk("arst_rel_re",    32'(mem_re),     32'h0);

`ifdef LSU_TIMEOUT_EN
        // Memory never answers: abandoned after TIMEOUT+1 MEM cycles
        issue(1'b0, 16'h0300, 16'h0);
        for (int i = 1; i <= 5; i++) begin
            chk("tmo_re",    32'(mem_re),     32'h1);
            chk("tmo_valid", 32'(resp_valid), 32'h0);
            @(negedge clk);
        end
        chk("tmo_resp",   32'(resp_valid), 32'h1);
        chk("tmo_err",    32'(resp_err),   32'h1);
        chk("tmo_rdata",  32'(resp_rdata), 32'h0);
        chk("tmo_re_off", 32'(mem_re),     32'h0);
        @(negedge clk);

        // Ready on the timeout cycle completes normally
        issue(1'b0, 16'h0301, 16'h0);
        for (int i = 1; i <= 5; i++) begin
            chk("tmo_edge_re", 32'(mem_re), 32'h1);
            if (i == 5) begin
                mem_ready = 1'b1;
                mem_rdata = 16'h1357;
            end
            @(negedge clk);
        end
        mem_ready = 1'b0;
        mem_rdata = 16'h0;
        chk("tmo_edge_resp",  32'(resp_valid), 32'h1);
        chk("tmo_edge_err",   32'(resp_err),   32'h0);
        chk("tmo_edge_rdata", 32'(resp_rdata), 32'h1357);
        @(negedge clk);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
